// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter sharing one tagged wb_ram slave (m0 fetch, m1 data).
// Define WB_ARB_FIXED_PRIO_EN to let m1 always win ties instead of round-robin.
module wb_ram_arbiter #(
  parameter int WB_DATA_WIDTH  = 32,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_SEL_WIDTH   = WB_DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_we_i,
  input  logic                     m0_cyc_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_check_tags_i,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,
  output logic                     m0_ack_o,
  output logic                     m0_err_o,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_we_i,
  input  logic                     m1_cyc_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_check_tags_i,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,
  output logic                     m1_ack_o,
  output logic                     m1_err_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_we_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_check_tags_o,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,
  input  logic                     s_ack_i,
  input  logic                     s_tag_mismatch_i,
  input  logic                     clear_mismatch_i,
  output logic                     s_clear_mismatch_o,
  output logic                     mismatch_owner_o,
  output logic                     mismatch_valid_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [WB_SEL_WIDTH-1:0] SEL_B = WB_SEL_WIDTH'(1);
  localparam logic [WB_SEL_WIDTH-1:0] SEL_H = WB_SEL_WIDTH'(3);

  logic [1:0]               state_q, state_d;
  logic                     last_q, last_d;
  logic                     own_q, own_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WB_DATA_WIDTH-1:0] data_q, data_d;
  logic [WB_SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                     we_q, we_d;
  logic                     chk_q, chk_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [1:0]               hold_q, hold_d;
  logic                     mm_prev_q;
  logic                     mm_own_q, mm_own_d;
  logic                     mm_vld_q, mm_vld_d;

  logic req0, req1, gnt, busy, hold, timeout;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_FIXED_PRIO_EN
  assign gnt = req1;
`else
  assign gnt = req1 & (~req0 | ~last_q);
`endif

  assign busy    = (state_q == S_BUSY);
  assign hold    = (state_q == S_HOLD);
  assign timeout = busy & ~s_ack_i & (tmo_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sel_d   = sel_q;
    we_d    = we_q;
    chk_d   = chk_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          own_d   = gnt;
          last_d  = gnt;
          addr_d  = gnt ? m1_addr_i : m0_addr_i;
          data_d  = gnt ? m1_data_i : m0_data_i;
          sel_d   = gnt ? m1_sel_i : m0_sel_i;
          we_d    = gnt ? m1_we_i : m0_we_i;
          chk_d   = gnt ? m1_check_tags_i : m0_check_tags_i;
          tmo_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (s_ack_i) begin
          // Sub-word writes need an extra cycle for the slave's read-modify-write
          if (we_q && (sel_q == SEL_B || sel_q == SEL_H))
            hold_d = 2'd2;
          else
            hold_d = 2'd1;
          state_d = S_HOLD;
        end else if (timeout) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q <= 2'd1)
          state_d = S_IDLE;
        else
          hold_d = hold_q - 2'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mm_own_d = mm_own_q;
    mm_vld_d = mm_vld_q;
    if (clear_mismatch_i) begin
      mm_vld_d = 1'b0;
    end else if (s_tag_mismatch_i && !mm_prev_q) begin
      mm_own_d = own_q;
      mm_vld_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      own_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      chk_q     <= 1'b0;
      tmo_q     <= '0;
      hold_q    <= 2'd0;
      mm_prev_q <= 1'b0;
      mm_own_q  <= 1'b0;
      mm_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      own_q     <= own_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      chk_q     <= chk_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      mm_prev_q <= s_tag_mismatch_i;
      mm_own_q  <= mm_own_d;
      mm_vld_q  <= mm_vld_d;
    end
  end

  assign s_cyc_o        = busy | hold;
  assign s_stb_o        = busy;
  assign s_we_o         = busy & we_q;
  assign s_addr_o       = addr_q;
  assign s_data_o       = data_q;
  assign s_sel_o        = sel_q;
  assign s_check_tags_o = (busy | hold) & chk_q;

  // A master that abandons its strobe still lets the slave finish, unacked
  assign m0_ack_o  = busy & ~own_q & s_ack_i & req0;
  assign m1_ack_o  = busy & own_q & s_ack_i & req1;
  assign m0_data_o = (busy & ~own_q) ? s_data_i : '0;
  assign m1_data_o = (busy & own_q) ? s_data_i : '0;
  assign m0_err_o  = timeout & ~own_q;
  assign m1_err_o  = timeout & own_q;

  assign s_clear_mismatch_o = clear_mismatch_i;
  assign mismatch_owner_o   = mm_own_q;
  assign mismatch_valid_o   = mm_vld_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: expected acks/errors queued at issue,
// popped by a monitor process; slave model acks on the 2nd strobe cycle.
module tb_wb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_check_tags_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_check_tags_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_check_tags_o;
  logic [31:0] s_data_i;
  logic        s_ack_i, s_tag_mismatch_i, clear_mismatch_i;
  logic        s_clear_mismatch_o, mismatch_owner_o, mismatch_valid_o;

  wb_ram_arbiter dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_check_tags_i(m0_check_tags_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_check_tags_i(m1_check_tags_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_check_tags_o(s_check_tags_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .s_tag_mismatch_i(s_tag_mismatch_i),
    .clear_mismatch_i(clear_mismatch_i),
    .s_clear_mismatch_o(s_clear_mismatch_o),
    .mismatch_owner_o(mismatch_owner_o),
    .mismatch_valid_o(mismatch_valid_o)
  );

  typedef struct packed {
    logic        err;
    logic        m;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_run = 0;
  int   n_fail = 0;
  logic slave_en = 1'b1;
  int   busy_cnt = 0;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return 32'hD00D_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic err, input logic m, input logic [31:0] d);
    exp_t e;
    e.err = err;
    e.m = m;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_ack_o | m1_ack_o | m0_err_o | m1_err_o) begin
        if (sbq.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL sb_unexpected: ack=%b%b err=%b%b with empty queue",
                   m1_ack_o, m0_ack_o, m1_err_o, m0_err_o);
        end else begin
          e = sbq.pop_front();
          chk("sb_kind", {31'd0, m0_err_o | m1_err_o}, {31'd0, e.err});
          chk("sb_master", {31'd0, m1_ack_o | m1_err_o}, {31'd0, e.m});
          if (!e.err) begin
            chk("sb_data", m1_ack_o ? m1_data_o : m0_data_o, e.data);
            chk("sb_other_data", m1_ack_o ? m0_data_o : m1_data_o, 32'd0);
          end
        end
      end
    end
  endtask

  task automatic slave();
    forever begin
      @(posedge clk);
      #1;
      if (s_stb_o) begin
        busy_cnt++;
        s_ack_i = slave_en && (busy_cnt == 2);
        s_data_i = rd_pat(s_addr_o);
      end else begin
        busy_cnt = 0;
        s_ack_i = 1'b0;
        s_data_i = '0;
      end
    end
  endtask

  task automatic req(input bit m, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] sel, input bit we, input bit ct);
    if (m) begin
      m1_addr_i = a; m1_data_i = d; m1_sel_i = sel;
      m1_we_i = we; m1_check_tags_i = ct;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    end else begin
      m0_addr_i = a; m0_data_i = d; m0_sel_i = sel;
      m0_we_i = we; m0_check_tags_i = ct;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    end
  endtask

  task automatic drop(input bit m);
    if (m) begin
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
    end else begin
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
    end
  endtask

  task automatic run_pending(input string name);
    int budget;
    bit d0, d1;
    budget = 200;
    while ((m0_cyc_i || m1_cyc_i) && budget > 0) begin
      @(negedge clk);
      d0 = m0_ack_o | m0_err_o;
      d1 = m1_ack_o | m1_err_o;
      @(posedge clk);
      #1;
      if (d0) drop(1'b0);
      if (d1) drop(1'b1);
      budget--;
    end
    chk({name, "_done"}, {31'd0, m0_cyc_i | m1_cyc_i}, 32'd0);
  endtask

  task automatic wait_ack1(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m1_ack_o && k < 20);
    chk(name, {31'd0, m1_ack_o}, 32'd1);
  endtask

  initial begin
    int nb, k;
    m0_addr_i = '0; m0_data_i = '0; m0_sel_i = '0; m0_we_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m0_check_tags_i = 0;
    m1_addr_i = '0; m1_data_i = '0; m1_sel_i = '0; m1_we_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_check_tags_i = 0;
    s_data_i = '0; s_ack_i = 0; s_tag_mismatch_i = 0; clear_mismatch_i = 0;
    fork
      slave();
      monitor();
    join_none

    #12;
    chk("rst_cyc", {31'd0, s_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, s_stb_o}, 32'd0);
    chk("rst_addr", s_addr_o, 32'd0);
    chk("rst_acks", {28'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 32'd0);
    chk("rst_mm_valid", {31'd0, mismatch_valid_o}, 32'd0);
    chk("rst_chk", {31'd0, s_check_tags_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single m0 read
    @(posedge clk); #1;
    req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
    push(1'b0, 1'b0, rd_pat(32'h10));
    run_pending("t1");
    @(negedge clk);
    chk("t1_hold_cyc", {31'd0, s_cyc_o}, 32'd1);
    chk("t1_hold_stb", {31'd0, s_stb_o}, 32'd0);
    chk("t1_hold_addr", s_addr_o, 32'h10);
    @(negedge clk);
    chk("t1_idle_cyc", {31'd0, s_cyc_o}, 32'd0);

    // simultaneous requests from fresh reset
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0);
    req(1'b1, 32'h200, 32'h0, 4'hF, 1'b0, 1'b0);
`ifdef WB_ARB_FIXED_PRIO_EN
    push(1'b0, 1'b1, rd_pat(32'h200));
    push(1'b0, 1'b0, rd_pat(32'h100));
`else
    push(1'b0, 1'b0, rd_pat(32'h100));
    push(1'b0, 1'b1, rd_pat(32'h200));
`endif
    run_pending("t2a");
    @(posedge clk); #1;
    req(1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 1'b0);
    req(1'b1, 32'h204, 32'h0, 4'hF, 1'b0, 1'b0);
`ifdef WB_ARB_FIXED_PRIO_EN
    push(1'b0, 1'b1, rd_pat(32'h204));
    push(1'b0, 1'b0, rd_pat(32'h104));
`else
    push(1'b0, 1'b0, rd_pat(32'h104));
    push(1'b0, 1'b1, rd_pat(32'h204));
`endif
    run_pending("t2b");

    // m1 byte write holds two cycles, m0 waits
    @(posedge clk); #1;
    req(1'b1, 32'h23, 32'h0000_00A5, 4'b0001, 1'b1, 1'b0);
    push(1'b0, 1'b1, rd_pat(32'h23));
    @(posedge clk); #1;
    req(1'b0, 32'h30, 32'h0, 4'hF, 1'b0, 1'b0);
    push(1'b0, 1'b0, rd_pat(32'h30));
    wait_ack1("t3_m1_ack");
    @(posedge clk); #1 drop(1'b1);
    @(negedge clk);
    chk("t3_h1_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd2);
    chk("t3_h1_addr", s_addr_o, 32'h23);
    chk("t3_h1_we", {31'd0, s_we_o}, 32'd0);
    chk("t3_h1_sel", {28'd0, s_sel_o}, 32'd1);
    @(negedge clk);
    chk("t3_h2_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd2);
    chk("t3_h2_addr", s_addr_o, 32'h23);
    @(negedge clk);
    chk("t3_idle_cyc", {31'd0, s_cyc_o}, 32'd0);
    run_pending("t3");

    // timeout on m1, then m0 served
    @(posedge clk); #1;
    slave_en = 1'b0;
    req(1'b1, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0);
    push(1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    req(1'b0, 32'h44, 32'h0, 4'hF, 1'b0, 1'b0);
    push(1'b0, 1'b0, rd_pat(32'h44));
    nb = 0;
    k = 0;
    do begin
      @(negedge clk);
      if (s_stb_o) nb++;
      k++;
    end while (!m1_err_o && k < 40);
    chk("t4_err_cycle", nb, 32'd15);
    @(posedge clk); #1;
    drop(1'b1);
    slave_en = 1'b1;
    @(negedge clk);
    chk("t4_cyc_dropped", {31'd0, s_cyc_o}, 32'd0);
    chk("t4_err_once", {31'd0, m1_err_o}, 32'd0);
    run_pending("t4");

    // tag mismatch attribution and clear priority
    @(posedge clk); #1;
    req(1'b1, 32'h80, 32'h0, 4'hF, 1'b0, 1'b1);
    push(1'b0, 1'b1, rd_pat(32'h80));
    wait_ack1("t5_m1_ack");
    chk("t5_busy_chk", {31'd0, s_check_tags_o}, 32'd1);
    @(posedge clk); #1;
    drop(1'b1);
    s_tag_mismatch_i = 1'b1;
    @(negedge clk);
    chk("t5_hold_chk", {31'd0, s_check_tags_o}, 32'd1);
    chk("t5_not_yet", {31'd0, mismatch_valid_o}, 32'd0);
    @(negedge clk);
    chk("t5_mm", {30'd0, mismatch_valid_o, mismatch_owner_o}, 32'd3);
    chk("t5_idle_chk", {31'd0, s_check_tags_o}, 32'd0);
    @(posedge clk); #1 s_tag_mismatch_i = 1'b0;
    @(posedge clk); #1;
    s_tag_mismatch_i = 1'b1;
    clear_mismatch_i = 1'b1;
    @(negedge clk);
    chk("t5_clr_fwd", {31'd0, s_clear_mismatch_o}, 32'd1);
    @(posedge clk); #1 clear_mismatch_i = 1'b0;
    @(negedge clk);
    chk("t5_clr_wins", {31'd0, mismatch_valid_o}, 32'd0);
    @(posedge clk); #1 s_tag_mismatch_i = 1'b0;

    // reset during BUSY
    @(posedge clk); #1;
    slave_en = 1'b0;
    req(1'b0, 32'h90, 32'h0, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_busy", {30'd0, s_cyc_o, s_stb_o}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    chk("t6_async_addr", s_addr_o, 32'd0);
    chk("t6_async_chk", {31'd0, s_check_tags_o}, 32'd0);
    drop(1'b0);
    slave_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req(1'b0, 32'hA0, 32'h0, 4'hF, 1'b0, 1'b0);
    req(1'b1, 32'hB0, 32'h0, 4'hF, 1'b0, 1'b0);
`ifdef WB_ARB_FIXED_PRIO_EN
    push(1'b0, 1'b1, rd_pat(32'hB0));
    push(1'b0, 1'b0, rd_pat(32'hA0));
`else
    push(1'b0, 1'b0, rd_pat(32'hA0));
    push(1'b0, 1'b1, rd_pat(32'hB0));
`endif
    run_pending("t6");

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
